// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage decode inputs and pipeline control outputs of the hazard controller
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    // ID-stage instruction description and memory handshake
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              rs1use;
    logic              rs2use;
    logic [1:0]        hazard_optype;
    logic              Branch_ID;
    logic              mem_ack;

    // Pipeline control produced by the controller
    logic [1:0]        forward_ctrl_A;
    logic [1:0]        forward_ctrl_B;
    logic              forward_ctrl_ls;
    logic              mem_req;
    logic              stall_PC;
    logic              stall_IFID;
    logic              stall_IDEX;
    logic              stall_EXMEM;
    logic              stall_MEMWB;
    logic              flush_IFID;
    logic              flush_IDEX;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rd, rs1use, rs2use, hazard_optype, Branch_ID, mem_ack,
        input  forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, mem_req,
        input  stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, stall_MEMWB,
        input  flush_IFID, flush_IDEX, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rd, rs1use, rs2use, hazard_optype, Branch_ID, mem_ack,
        output forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, mem_req,
        output stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, stall_MEMWB,
        output flush_IFID, flush_IDEX, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard controller: forwarding, load-use/memory stalls, branch flush
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_LD   = 2'b11;

    // One scoreboard entry: destination, hazard op type and store-data source register
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [1:0]        op;
        logic [REG_AW-1:0] rs2;
    } slot_t;

    localparam slot_t BUBBLE = '0;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    // WB only needs rd/op: its rs2 is never consulted
    slot_t             ex_q, ex_d;
    slot_t             mem_q, mem_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [1:0]        wb_op_q, wb_op_d;
    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic mem_access;
    logic mem_busy;
    logic load_use_rs1;
    logic load_use_rs2;
    logic load_use;
    logic branch_flush;

    // A slot with rd==x0 never produces a value, so it matches nothing
    function automatic logic slot_hit(input slot_t s, input logic [1:0] op,
                                      input logic [REG_AW-1:0] rs);
        return (s.rd != '0) && (s.op == op) && (s.rd == rs);
    endfunction

    // Youngest producer wins: EX ALU result, then MEM ALU result, then MEM load data
    function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [REG_AW-1:0] rs,
                                           input slot_t ex_s, input slot_t mem_s);
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_rs && (rs != '0)) begin
            if (slot_hit(ex_s, OP_ALU, rs)) begin
                sel = FWD_EX;
            end else if (slot_hit(mem_s, OP_ALU, rs)) begin
                sel = FWD_MEM;
            end else if (slot_hit(mem_s, OP_LOAD, rs)) begin
                sel = FWD_LD;
            end
        end
        return sel;
    endfunction

    // Hazard detection with priority memory wait > load-use > taken branch
    always_comb begin
        mem_access   = (mem_q.op == OP_LOAD) || (mem_q.op == OP_STORE);
        mem_busy     = mem_access && !hz.mem_ack;
        load_use_rs1 = hz.rs1use && slot_hit(ex_q, OP_LOAD, hz.id_rs1);
        // Store data can be forwarded later from WB, so a store's rs2 never stalls
        load_use_rs2 = hz.rs2use && (hz.hazard_optype != OP_STORE)
                       && slot_hit(ex_q, OP_LOAD, hz.id_rs2);
        load_use     = !mem_busy && (load_use_rs1 || load_use_rs2);
        branch_flush = !mem_busy && !load_use && hz.Branch_ID;
    end

    // Memory FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory FSM next state: enter WAIT on an unacknowledged access, leave on ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: if (mem_busy)   state_d = MEM_WAIT;
            MEM_WAIT: if (hz.mem_ack) state_d = MEM_IDLE;
            default:                  state_d = MEM_IDLE;
        endcase
    end

    // Memory FSM output: request follows the MEM op and is held throughout WAIT
    always_comb begin
        hz.mem_req = mem_access || (state_q == MEM_WAIT);
    end

    // Scoreboard advance: hold on memory wait, bubble into EX on load-use
    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_rd_d = wb_rd_q;
        wb_op_d = wb_op_q;
        if (!mem_busy) begin
            mem_d   = ex_q;
            wb_rd_d = mem_q.rd;
            wb_op_d = mem_q.op;
            if (load_use) begin
                ex_d = BUBBLE;
            end else begin
                ex_d.rd  = hz.id_rd;
                ex_d.op  = hz.hazard_optype;
                ex_d.rs2 = hz.id_rs2;
            end
        end
    end

    // Scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= BUBBLE;
            mem_q   <= BUBBLE;
            wb_rd_q <= '0;
            wb_op_q <= OP_NONE;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_rd_q <= wb_rd_d;
            wb_op_q <= wb_op_d;
        end
    end

    // Saturating event counters: they stick at all-ones rather than wrap
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((mem_busy || load_use) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Pipeline stall/flush and forwarding outputs
    always_comb begin
        hz.stall_PC    = 1'b0;
        hz.stall_IFID  = 1'b0;
        hz.stall_IDEX  = 1'b0;
        hz.stall_EXMEM = 1'b0;
        hz.stall_MEMWB = 1'b0;
        hz.flush_IFID  = 1'b0;
        hz.flush_IDEX  = 1'b0;
        if (mem_busy) begin
            hz.stall_PC    = 1'b1;
            hz.stall_IFID  = 1'b1;
            hz.stall_IDEX  = 1'b1;
            hz.stall_EXMEM = 1'b1;
            hz.stall_MEMWB = 1'b1;
        end else if (load_use) begin
            hz.stall_PC    = 1'b1;
            hz.stall_IFID  = 1'b1;
            hz.flush_IDEX  = 1'b1;
        end else if (branch_flush) begin
            hz.flush_IFID  = 1'b1;
        end
        hz.forward_ctrl_A  = fwd_sel(hz.rs1use, hz.id_rs1, ex_q, mem_q);
        hz.forward_ctrl_B  = fwd_sel(hz.rs2use, hz.id_rs2, ex_q, mem_q);
        hz.forward_ctrl_ls = (mem_q.op == OP_STORE) && (wb_op_q == OP_LOAD)
                             && (wb_rd_q != '0) && (mem_q.rs2 == wb_rd_q);
        hz.stall_cnt       = stall_cnt_q;
        hz.flush_cnt       = flush_cnt_q;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int NVEC   = 33;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2;
        logic [1:0] op;
        logic       br, ack;
        logic [1:0] fa, fb;
        logic       ls, mreq;
        logic [4:0] st;
        logic [1:0] fl;
        logic [3:0] sc, fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[NVEC];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    function automatic vec_t mk(input int rs1, input int rs2, input int rd, input int u1,
                                input int u2, input int op, input int br, input int ack,
                                input int fa, input int fb, input int ls, input int mreq,
                                input int st, input int fl, input int sc, input int fc);
        vec_t v;
        v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0]; v.rd = rd[4:0];
        v.u1 = u1[0]; v.u2 = u2[0]; v.op = op[1:0]; v.br = br[0]; v.ack = ack[0];
        v.fa = fa[1:0]; v.fb = fb[1:0]; v.ls = ls[0]; v.mreq = mreq[0];
        v.st = st[4:0]; v.fl = fl[1:0]; v.sc = sc[3:0]; v.fc = fc[3:0];
        return v;
    endfunction

    function automatic vec_t nop(input int ack, input int mreq, input int ls, input int st,
                                 input int sc, input int fc);
        return mk(0, 0, 0, 0, 0, 0, 0, ack, 0, 0, ls, mreq, st, 0, sc, fc);
    endfunction

    task automatic drive(input vec_t v);
        hz.id_rs1        = v.rs1;
        hz.id_rs2        = v.rs2;
        hz.id_rd         = v.rd;
        hz.rs1use        = v.u1;
        hz.rs2use        = v.u2;
        hz.hazard_optype = v.op;
        hz.Branch_ID     = v.br;
        hz.mem_ack       = v.ack;
    endtask

    task automatic check_out(input string name);
        vec_t       e;
        logic [4:0] st;
        logic [1:0] fl;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, no expected record", name);
        end else begin
            e  = exp_q.pop_front();
            st = {hz.stall_PC, hz.stall_IFID, hz.stall_IDEX, hz.stall_EXMEM, hz.stall_MEMWB};
            fl = {hz.flush_IFID, hz.flush_IDEX};
            if (hz.forward_ctrl_A !== e.fa || hz.forward_ctrl_B !== e.fb ||
                hz.forward_ctrl_ls !== e.ls || hz.mem_req !== e.mreq || st !== e.st ||
                fl !== e.fl || hz.stall_cnt !== e.sc || hz.flush_cnt !== e.fc) begin
                errors++;
                $display("FAIL %s: got fa=%b fb=%b ls=%b req=%b stall=%b flush=%b scnt=%0d fcnt=%0d | want fa=%b fb=%b ls=%b req=%b stall=%b flush=%b scnt=%0d fcnt=%0d",
                         name, hz.forward_ctrl_A, hz.forward_ctrl_B, hz.forward_ctrl_ls,
                         hz.mem_req, st, fl, hz.stall_cnt, hz.flush_cnt,
                         e.fa, e.fb, e.ls, e.mreq, e.st, e.fl, e.sc, e.fc);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        check_out(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rs1 rs2 rd u1 u2 op br ack | fa fb ls mreq stall flush scnt fcnt
        tbl[0]  = nop(1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(2, 3, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);          // add x1,x2,x3
        tbl[2]  = mk(1, 5, 4, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);          // add x4,x1,x5
        tbl[3]  = mk(1, 4, 7, 1, 1, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0);          // add x7,x1,x4
        tbl[4]  = nop(1, 0, 0, 0, 0, 0);
        tbl[5]  = nop(1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(2, 0, 5, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);          // lw x5
        tbl[7]  = mk(5, 7, 6, 1, 1, 1, 0, 1, 0, 0, 0, 0, 5'b11000, 2'b01, 0, 0); // add x6,x5,x7
        tbl[8]  = mk(5, 7, 6, 1, 1, 1, 0, 1, 3, 0, 0, 1, 0, 0, 1, 0);          // replay
        tbl[9]  = nop(1, 0, 0, 0, 1, 0);
        tbl[10] = mk(2, 0, 5, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);          // lw x5
        tbl[11] = mk(2, 5, 0, 1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);          // sw x5
        tbl[12] = nop(1, 1, 0, 0, 1, 0);
        tbl[13] = nop(1, 1, 1, 0, 1, 0);
        tbl[14] = nop(1, 0, 0, 0, 1, 0);
        tbl[15] = mk(1, 2, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 2'b10, 1, 0);      // beq taken
        tbl[16] = nop(1, 0, 0, 0, 1, 1);
        tbl[17] = mk(2, 0, 3, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);          // lw x3
        tbl[18] = mk(3, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 5'b11000, 2'b01, 1, 1); // beq x3 + load-use
        tbl[19] = mk(3, 0, 0, 1, 1, 0, 1, 1, 3, 0, 0, 1, 0, 2'b10, 2, 1);      // beq replay
        tbl[20] = nop(1, 0, 0, 0, 2, 2);
        tbl[21] = mk(2, 0, 8, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 2, 2);          // lw x8
        tbl[22] = nop(1, 0, 0, 0, 2, 2);
        tbl[23] = nop(0, 1, 0, 5'b11111, 2, 2);
        tbl[24] = nop(0, 1, 0, 5'b11111, 3, 2);
        tbl[25] = nop(0, 1, 0, 5'b11111, 4, 2);
        tbl[26] = nop(1, 1, 0, 0, 5, 2);
        tbl[27] = nop(1, 0, 0, 0, 5, 2);
        tbl[28] = mk(1, 2, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5, 2);          // add x0,x1,x2
        tbl[29] = mk(0, 0, 3, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5, 2);          // add x3,x0,x0
        tbl[30] = mk(2, 0, 0, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 5, 2);          // lw x0
        tbl[31] = mk(0, 3, 4, 1, 1, 1, 0, 1, 0, 2, 0, 0, 0, 0, 5, 2);          // add x4,x0,x3
        tbl[32] = nop(1, 1, 0, 0, 5, 2);

        drive(nop(1, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #2;
        exp_q.push_back(nop(1, 0, 0, 0, 0, 0));
        check_out("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Long memory wait: counter saturates at all-ones
        apply(mk(2, 0, 9, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 5, 2), "lw_x9");
        apply(nop(1, 0, 0, 0, 5, 2), "lw_x9_to_mem");
        for (int i = 0; i < 13; i++) begin
            apply(nop(0, 1, 0, 5'b11111, (5 + i > 15) ? 15 : 5 + i, 2), $sformatf("sat%0d", i));
        end

        // Asynchronous reset in the middle of the memory stall
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(nop(0, 0, 0, 0, 0, 0));
        check_out("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(nop(0, 0, 0, 0, 0, 0), "post_reset_ack0");
        apply(nop(1, 0, 0, 0, 0, 0), "post_reset_ack1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core.
- Tracks destination register and hazard op type of instructions in EX, MEM and WB with an internal scoreboard.
- Generates ID-stage forwarding selects, load-use stalls, taken-branch flushes and data-memory wait stalls.
- Sits beside the ID-stage control decoder and consumes its rs1use/rs2use/hazard_optype/Branch outputs.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of the saturating stall/flush event counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_AW  ID-stage rs1 address.
- id_rs2  in  REG_AW  ID-stage rs2 address.
- id_rd  in  REG_AW  ID-stage rd address.
- rs1use  in  1  ID instruction reads rs1.
- rs2use  in  1  ID instruction reads rs2.
- hazard_optype  in  2  ID op type: 00 none, 01 ALU-writeback (incl. JAL/JALR/LUI/AUIPC), 10 load, 11 store.
- Branch_ID  in  1  ID control-transfer taken (branch resolved in ID, or jump).
- mem_ack  in  1  data memory completes access this cycle.
- forward_ctrl_A  out  2  rs1 source: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
- forward_ctrl_B  out  2  rs2 source, same encoding.
- forward_ctrl_ls  out  1  store in MEM takes store data from WB load data.
- mem_req  out  1  data memory request held while waiting.
- stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, stall_MEMWB  out  1 each  hold the named register.
- flush_IFID, flush_IDEX  out  1 each  insert bubble into the named register.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Scoreboard slots EX, MEM, WB: {rd, op, rs2}; rd==0 is treated as op 00 for matching.
- Reset (async, rst_n=0): all slot ops=00, rd=0; mem FSM=IDLE; counters=0.
- Stall/flush/forward outputs are combinational from slots and inputs; all are 0 immediately after reset.
- Memory FSM, IDLE->WAIT:
  - Triggered when MEM op is 10/11 and mem_ack=0.
  - mem_req=1 whenever MEM op is 10/11; it holds in WAIT.
  - WAIT->IDLE on mem_ack=1.
  - mem_busy = (MEM op is 10/11) & !mem_ack.
- Priority, highest first: mem_busy > load-use > Branch_ID.
- mem_busy:
  - All five stall_* = 1, no flush, slots hold.
  - stall_cnt +1 per cycle.
- Load-use:
  - Condition: EX op=10 and EX rd matches (rs1use & id_rs1) or (rs2use & id_rs2 with ID op != 11).
  - Response: stall_PC = stall_IFID = 1, flush_IDEX = 1.
  - Next cycle: EX slot <= bubble, MEM <= EX.
  - Branch_ID is ignored that cycle; stall_cnt +1.
- Store after load (ID op=11, rs2 matches EX load rd): no stall.
  - forward_ctrl_ls=1 when MEM op=11, WB op=10 and MEM rs2 == WB rd != 0.
- Forwarding per operand, only when use bit set and rs != 0:
  - EX op=01 match -> 01.
  - Else MEM op=01 match -> 10.
  - Else MEM op=10 match -> 11.
  - Else 00. EX has priority over MEM.
- Branch_ID with no higher-priority event: flush_IFID=1 for one cycle; flush_cnt +1.
- Normal advance: EX <= ID {rd, optype, rs2}; MEM <= EX; WB <= MEM.
- Counters saturate at all-ones, no wrap.
- Reset asserted mid-stall clears everything in the same cycle with no clock needed.

Test Plan:
- add x1,x2,x3 then add x4,x1,x5 -> forward_ctrl_A=01, no stall, flush=0.
- lw x5,0(x2) then add x6,x5,x7:
  - Cycle 1: stall_PC=stall_IFID=flush_IDEX=1, stall_cnt=1.
  - Cycle 2: forward_ctrl_A=11.
- lw x5 then sw x5,0(x2) -> no stall; two cycles later forward_ctrl_ls=1 for one cycle.
- beq taken (Branch_ID=1) with no hazard -> flush_IFID=1 one cycle, flush_cnt=1; with simultaneous load-use -> flush_IFID=0.
- Load in MEM with mem_ack low 3 cycles:
  - All stall_*=1 and mem_req=1 for 3 cycles, stall_cnt=3.
  - Release on mem_ack=1.
- Writes to x0 followed by reads of x0 -> forward selects 00.
- rst_n=0 during a mem stall -> all outputs 0 asynchronously, counters 0.
